// File: rtl/crypto_result_serializer.sv
// Serialises a 255-bit key-exchange result into a 32-bit valid/ready/last packet, LSW first.
// Optional checksum word after the data words: define CRYPTO_SER_CHECKSUM_EN.
module crypto_result_serializer #(
  parameter int DATA_W = 255,
  parameter int WORD_W = 32
) (
  input  logic              crypto_clk,
  input  logic              crypto_reset,
  input  logic [DATA_W-1:0] ser_data_in,
  input  logic              ser_data_valid,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              ser_busy,
  output logic              ser_overrun
);

  localparam int NUM_WORDS = (DATA_W + WORD_W) / WORD_W;
  localparam int SH_W      = NUM_WORDS * WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

`ifdef CRYPTO_SER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;
`endif

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              ovr_q, ovr_d;
  logic              rise;
  logic              hs;
`ifdef CRYPTO_SER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
`endif

  assign rise     = ser_data_valid && !valid_q;
  assign m_tvalid = (state_q != IDLE);
  assign hs       = m_tvalid && m_tready;
  assign ser_busy = (state_q != IDLE);
  assign ser_overrun = ovr_q;

  // Next-state: capture on a rising valid edge, shift one word per handshake.
  always_comb begin
    state_d = state_q;
    valid_d = ser_data_valid;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ovr_d   = ovr_q | (rise && (state_q != IDLE));
`ifdef CRYPTO_SER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          sh_d    = {{(SH_W-DATA_W){1'b0}}, ser_data_in};
          cnt_d   = '0;
          state_d = SEND;
`ifdef CRYPTO_SER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      SEND: begin
        if (hs) begin
          sh_d  = {{WORD_W{1'b0}}, sh_q[SH_W-1:WORD_W]};
          cnt_d = cnt_q + CNT_W'(1);
`ifdef CRYPTO_SER_CHECKSUM_EN
          csum_d = csum_q ^ sh_q[WORD_W-1:0];
          if (cnt_q == LAST_CNT) state_d = CSUM;
`else
          if (cnt_q == LAST_CNT) state_d = IDLE;
`endif
        end
      end
`ifdef CRYPTO_SER_CHECKSUM_EN
      CSUM: begin
        if (hs) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output word and last marker derived from registered state only.
  always_comb begin
    m_tdata = '0;
    m_tlast = 1'b0;
    unique case (state_q)
      SEND: begin
        m_tdata = sh_q[WORD_W-1:0];
`ifndef CRYPTO_SER_CHECKSUM_EN
        m_tlast = (cnt_q == LAST_CNT);
`endif
      end
`ifdef CRYPTO_SER_CHECKSUM_EN
      CSUM: begin
        m_tdata = csum_q;
        m_tlast = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge crypto_clk or posedge crypto_reset) begin
    if (crypto_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ovr_q   <= 1'b0;
`ifdef CRYPTO_SER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ovr_q   <= ovr_d;
`ifdef CRYPTO_SER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_crypto_result_serializer.sv
// Scoreboard bench for crypto_result_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_crypto_result_serializer;

`ifdef CRYPTO_SER_CHECKSUM_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif

  logic         crypto_clk = 1'b0;
  logic         crypto_reset;
  logic [254:0] ser_data_in;
  logic         ser_data_valid;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         ser_busy;
  logic         ser_overrun;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int pkt_cnt = 0;
  logic        st_seen = 1'b0;
  logic [31:0] st_d;
  logic        st_l;

  crypto_result_serializer dut (
    .crypto_clk     (crypto_clk),
    .crypto_reset   (crypto_reset),
    .ser_data_in    (ser_data_in),
    .ser_data_valid (ser_data_valid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
    .ser_busy       (ser_busy),
    .ser_overrun    (ser_overrun)
  );

  always #5 crypto_clk = ~crypto_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic push_packet(input logic [254:0] v);
    logic [255:0] s;
    logic [31:0]  w;
    logic [31:0]  x;
    s = {1'b0, v};
    x = '0;
    for (int i = 0; i < 8; i++) begin
      w = s[32*i +: 32];
      x ^= w;
      exp_q.push_back('{d: w, l: (i == 7) && (NW == 8)});
    end
`ifdef CRYPTO_SER_CHECKSUM_EN
    exp_q.push_back('{d: x, l: 1'b1});
`endif
  endtask

  task automatic send(input logic [254:0] v);
    @(posedge crypto_clk); #1;
    ser_data_in = v;
    push_packet(v);
    ser_data_valid = 1'b1;
    @(posedge crypto_clk); #1;
    ser_data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(posedge crypto_clk); #2;
      if (!ser_busy) break;
    end
    chk("idle_timeout", ser_busy, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic wait_hs(input int n);
    for (int k = 0; k < 100; k++) begin
      @(posedge crypto_clk); #2;
      if (hs_cnt >= n) break;
    end
    chk("hs_timeout", hs_cnt >= n, 1);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_tvalid"}, m_tvalid, 0);
    chk({nm, "_tdata"}, m_tdata, 0);
    chk({nm, "_tlast"}, m_tlast, 0);
    chk({nm, "_busy"}, ser_busy, 0);
    chk({nm, "_overrun"}, ser_overrun, 0);
  endtask

  // Monitor: stream stability during stalls and scoreboard compare on handshakes.
  always @(negedge crypto_clk) begin
    if (crypto_reset) begin
      st_seen = 1'b0;
    end else begin
      if (st_seen) begin
        chk("valid_hold", m_tvalid, 1);
        chk("stall_data", m_tdata, st_d);
        chk("stall_last", m_tlast, st_l);
      end
      st_seen = m_tvalid && !m_tready;
      st_d = m_tdata;
      st_l = m_tlast;
      if (m_tvalid && m_tready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word: got %0h expected none", m_tdata);
        end else begin
          exp_t e;
          n_pass++;
          e = exp_q.pop_front();
          chk("word_data", m_tdata, e.d);
          chk("word_last", m_tlast, e.l);
        end
        hs_cnt++;
        if (m_tlast) pkt_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    int cyc;
    logic [255:0] pat;
    crypto_reset = 1'b1;
    ser_data_valid = 1'b0;
    ser_data_in = '0;
    m_tready = 1'b0;
    #1;
    chk_outs_zero("reset");
    repeat (3) @(posedge crypto_clk);
    #1 crypto_reset = 1'b0;

    // Single-bit result, ready held high, latency check.
    m_tready = 1'b1;
    b = hs_cnt;
    @(posedge crypto_clk); #1;
    ser_data_in = 255'h1;
    push_packet(255'h1);
    ser_data_valid = 1'b1;
    chk("pre_edge_tvalid", m_tvalid, 0);
    @(posedge crypto_clk); #1;
    chk("latency_tvalid", m_tvalid, 1);
    chk("latency_busy", ser_busy, 1);
    chk("first_word", m_tdata, 32'h1);
    ser_data_valid = 1'b0;
    wait_idle();
    chk("t1_words", hs_cnt - b, NW);

    // All ones.
    send({255{1'b1}});
    wait_idle();

    // Alternating ready, pattern data.
    pat = {4{64'h0123456789ABCDEF}};
    m_tready = 1'b0;
    @(posedge crypto_clk); #1;
    ser_data_in = pat[254:0];
    push_packet(pat[254:0]);
    ser_data_valid = 1'b1;
    @(posedge crypto_clk); #1;
    ser_data_valid = 1'b0;
    cyc = 0;
    while (m_tvalid && cyc < 40) begin
      m_tready = (cyc % 2 == 1);
      @(posedge crypto_clk); #1;
      cyc++;
    end
    chk("t3_cycles", cyc, 2 * NW);
    m_tready = 1'b1;
    wait_idle();

    // Level held high for 50 cycles: one packet only.
    b = pkt_cnt;
    @(posedge crypto_clk); #1;
    ser_data_in = 255'h5A5A_0000_1234;
    push_packet(255'h5A5A_0000_1234);
    ser_data_valid = 1'b1;
    repeat (50) @(posedge crypto_clk);
    #1 ser_data_valid = 1'b0;
    wait_idle();
    chk("t4_packets", pkt_cnt - b, 1);
    chk("t4_overrun", ser_overrun, 0);

    // Second edge during word 3: dropped, overrun sticky.
    b = hs_cnt;
    send(255'hCAFE_BABE_0000_0001);
    wait_hs(b + 3);
    ser_data_in = 255'hDEAD;
    ser_data_valid = 1'b1;
    @(posedge crypto_clk); #1;
    ser_data_valid = 1'b0;
    chk("t5_overrun_set", ser_overrun, 1);
    wait_idle();
    send(255'h7777_0000_8888);
    wait_idle();
    chk("t5_overrun_sticky", ser_overrun, 1);

    // Reset at word 4, then a fresh packet.
    b = hs_cnt;
    send(255'hFEDC_BA98_7654_3210);
    wait_hs(b + 4);
    crypto_reset = 1'b1;
    #1;
    chk_outs_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge crypto_clk);
    #1 crypto_reset = 1'b0;
    send(255'h00AB_CDEF);
    wait_idle();
    chk("t6_overrun", ser_overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
